coo_edge_sequencer: RTL and testbench
=====================================

# coo_edge_sequencer

Parametrised successor to the fixed-count COO edge FSM in the graph-aggregation datapath. It walks a runtime-programmable number of COO edges. For each edge it issues an adjacency-read/write pass, then a feature×weight-read/write pass, and waits on a memory-ready handshake in each read phase. It owns the edge counter, supports abort and restart, and returns to idle after signalling completion, so the aggregation controller can issue back-to-back jobs.

## Interface
- `MAX_EDGES`, default 64, largest edge count per job.
- `EDGE_BW`, default `$clog2(MAX_EDGES+1)`, width of the edge count and index.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `num_edges`  in  EDGE_BW  edges in this job; latched on accepted `start`.
- `abort`  in  1  synchronous job cancel.
- `mem_ready`  in  1  read data valid for the current read phase.
- `edge_skip`  in  1  skip the current edge (see Configuration).
- `adj_rd_en`  out  1  adjacency memory read enable.
- `fmwm_rd_en`  out  1  feature×weight memory read enable.
- `wr_en`  out  1  write enable to the FM/WM/ADJ result store.
- `edge_inc`  out  1  one-cycle pulse when an edge retires.
- `edge_idx`  out  EDGE_BW  index of the current edge.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ADJ_RD, ADJ_WR, FM_RD, FM_WR, INC, DONE.
- Outputs are Moore-decoded from state, except `edge_idx`, which is a register.
- **IDLE**
  - All strobes are 0.
  - On `start`: latch `min(num_edges, MAX_EDGES)` and clear `edge_idx` to 0.
  - If the latched count is 0, go to DONE; otherwise go to ADJ_RD.
- **ADJ_RD**
  - `adj_rd_en`=1.
  - Hold in this state while `mem_ready`=0; go to ADJ_WR when `mem_ready`=1.
- **ADJ_WR**
  - `adj_rd_en`=1 and `wr_en`=1 for exactly one cycle, then go to FM_RD.
- **FM_RD**
  - `fmwm_rd_en`=1.
  - Hold in this state while `mem_ready`=0; go to FM_WR when `mem_ready`=1.
- **FM_WR**
  - `fmwm_rd_en`=1 and `wr_en`=1 for one cycle, then go to INC.
- **INC**
  - `edge_inc`=1.
  - If `edge_idx` == latched count − 1, go to DONE and hold `edge_idx`.
  - Otherwise increment `edge_idx` and go to ADJ_RD.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE. `edge_idx` keeps its final value.
- `busy`=1 in every state except IDLE and DONE.
- `start` outside IDLE is ignored. `num_edges` changes after acceptance have no effect.
- `abort` in any non-IDLE state:
  - Go to IDLE on the next edge.
  - No `done` pulse and no `edge_inc`.
  - `edge_idx` is held.
  - `abort` takes priority over all other transitions.
- `reset`, including mid-job, puts all of the following to 0 on the next edge: state IDLE, `edge_idx`, latched count, and every output.
- `mem_ready` is ignored outside the two read states.

## Timing
- Per-edge latency with `mem_ready` tied 1 is 5 cycles.
- Each wait cycle in ADJ_RD or FM_RD adds 1 cycle.
- Job timeline, with `start` sampled in cycle 0:
  - Edge k occupies cycles 5k+1 through 5k+5.
  - `done` is high in cycle 5N+1.
  - IDLE resumes in cycle 5N+2, and a new `start` can be accepted in that cycle.
- Zero-edge job: `done` in cycle 1 and no strobes at all.
- The `edge_idx` update is visible in the cycle after INC.

## Configuration
- Macro: `COO_EDGE_SKIP_EN`.
- **Defined:**
  - `edge_skip` is sampled in ADJ_RD in the cycle where `mem_ready`=1.
  - If `edge_skip` is 1, the FSM goes straight to INC. ADJ_WR, FM_RD and FM_WR are bypassed, so no `wr_en` and no `fmwm_rd_en` occur for that edge.
  - A skipped edge takes 2 cycles when `mem_ready` is tied 1.
- **Undefined:** `edge_skip` is ignored, and every edge takes the full 5-state pass.

## Test plan
- `num_edges`=3, `mem_ready`=1 → `done` at cycle 16; 3 `edge_inc` pulses at cycles 5, 10, 15; 6 `wr_en` pulses; final `edge_idx`=2.
- `num_edges`=0 → `done` at cycle 1; `busy`, `adj_rd_en`, `fmwm_rd_en` and `wr_en` never asserted.
- `num_edges`=2 with `mem_ready` low for 3 cycles in each FM_RD → `done` at cycle 17.
- `abort` during edge 1 FM_RD of a 4-edge job → IDLE the next cycle, no `done`, `edge_idx`=1.
- A new `start` during a job is ignored. A `start` in the cycle after `done` runs a full second job with `edge_idx` restarting at 0.
- With `COO_EDGE_SKIP_EN`: 3 edges, `edge_skip`=1 on edge 1 → 4 `wr_en` pulses, `done` at cycle 13. Without the macro, the same stimulus gives `done` at cycle 16.

Source files
------------

// File: rtl/coo_edge_sequencer.sv
// COO edge sequencer: walks a programmable number of edges, ADJ read/write then FM/WM read/write per edge.
// Latency: 5 cycles per edge with mem_ready held high, +1 per wait cycle in a read phase; done one cycle after last INC.
// Backpressure: stalls in ADJ_RD/FM_RD until mem_ready; abort returns to IDLE next cycle. Optional COO_EDGE_SKIP_EN enables edge_skip.
module coo_edge_sequencer #(
  parameter int MAX_EDGES = 64,
  parameter int EDGE_BW   = $clog2(MAX_EDGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [EDGE_BW-1:0] num_edges,
  input  logic               abort,
  input  logic               mem_ready,
  input  logic               edge_skip,
  output logic               adj_rd_en,
  output logic               fmwm_rd_en,
  output logic               wr_en,
  output logic               edge_inc,
  output logic [EDGE_BW-1:0] edge_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADJ_RD = 3'd1,
    ST_ADJ_WR = 3'd2,
    ST_FM_RD  = 3'd3,
    ST_FM_WR  = 3'd4,
    ST_INC    = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam logic [EDGE_BW-1:0] MAX_E = EDGE_BW'(MAX_EDGES);
  localparam logic [EDGE_BW-1:0] ONE_E = EDGE_BW'(1);

  state_t             state;
  state_t             state_nxt;
  logic [EDGE_BW-1:0] edge_cnt;
  logic [EDGE_BW-1:0] num_clamped;
  logic               last_edge;
  logic               skip_now;

  assign num_clamped = (num_edges > MAX_E) ? MAX_E : num_edges;
  assign last_edge   = (edge_idx == (edge_cnt - ONE_E));

`ifdef COO_EDGE_SKIP_EN
  assign skip_now = edge_skip;
`else
  // Skip is compiled out; the port stays so both builds share one footprint.
  logic unused_edge_skip;
  assign unused_edge_skip = edge_skip;
  assign skip_now         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; abort overrides every transition outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (num_edges == '0) ? ST_DONE : ST_ADJ_RD;
      end
      ST_ADJ_RD: begin
        if (mem_ready) state_nxt = skip_now ? ST_INC : ST_ADJ_WR;
      end
      ST_ADJ_WR: state_nxt = ST_FM_RD;
      ST_FM_RD: begin
        if (mem_ready) state_nxt = ST_FM_WR;
      end
      ST_FM_WR:  state_nxt = ST_INC;
      ST_INC:    state_nxt = last_edge ? ST_DONE : ST_ADJ_RD;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  // Edge count latch and edge index counter; index is held on abort and at the last edge
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt <= '0;
      edge_idx <= '0;
    end else if (state == ST_IDLE && start) begin
      edge_cnt <= num_clamped;
      edge_idx <= '0;
    end else if (state == ST_INC && !abort && !last_edge) begin
      edge_idx <= edge_idx + ONE_E;
    end
  end

  // Moore output decode
  always_comb begin
    adj_rd_en  = 1'b0;
    fmwm_rd_en = 1'b0;
    wr_en      = 1'b0;
    edge_inc   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_ADJ_RD: begin adj_rd_en = 1'b1; busy = 1'b1; end
      ST_ADJ_WR: begin adj_rd_en = 1'b1; wr_en = 1'b1; busy = 1'b1; end
      ST_FM_RD:  begin fmwm_rd_en = 1'b1; busy = 1'b1; end
      ST_FM_WR:  begin fmwm_rd_en = 1'b1; wr_en = 1'b1; busy = 1'b1; end
      ST_INC:    begin edge_inc = 1'b1; busy = 1'b1; end
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_coo_edge_sequencer.sv
// Bench for coo_edge_sequencer: builds each job's expected cycle trace from the edge/phase rules and compares every cycle.
// Timing: inputs driven and outputs sampled 1 time unit after the rising edge.
// Randomized read waits, ignored start/num_edges/mem_ready noise, aborts and resets.
module tb_coo_edge_sequencer;

  localparam int MAXE = 64;
  localparam int EB   = 7;

  logic          clk = 1'b0;
  logic          reset, start, abort, mem_ready, edge_skip;
  logic [EB-1:0] num_edges;
  logic          adj_rd_en, fmwm_rd_en, wr_en, edge_inc, busy, done;
  logic [EB-1:0] edge_idx;

  coo_edge_sequencer #(.MAX_EDGES(MAXE), .EDGE_BW(EB)) dut (
    .clk(clk), .reset(reset), .start(start), .num_edges(num_edges),
    .abort(abort), .mem_ready(mem_ready), .edge_skip(edge_skip),
    .adj_rd_en(adj_rd_en), .fmwm_rd_en(fmwm_rd_en), .wr_en(wr_en),
    .edge_inc(edge_inc), .edge_idx(edge_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {adj_rd_en, fmwm_rd_en, wr_en, edge_inc, busy, done}
  logic [5:0] obs;
  assign obs = {adj_rd_en, fmwm_rd_en, wr_en, edge_inc, busy, done};

  // One expected cycle: outputs, edge index, and what to drive (2 = random don't-care)
  typedef struct {
    logic [5:0]    o;
    logic [EB-1:0] idx;
    int            mr;
    int            sk;
  } step_t;

  step_t   q[$];
  int      checks = 0;
  int      errors = 0;
  int      wa[MAXE];
  int      wf[MAXE];
  logic [EB-1:0] m_idx;
  int      dc, wc;

  function automatic step_t mk(input logic [5:0] o, input int idx, input int mr, input int sk);
    step_t s;
    s.o = o; s.idx = EB'(idx); s.mr = mr; s.sk = sk;
    return s;
  endfunction

  function automatic bit skip_active(input int k, input int skip_e);
`ifdef COO_EDGE_SKIP_EN
    return (k == skip_e);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_o(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Job model: per edge, ADJ read (waits+1), ADJ write, FM read (waits+1), FM write, INC; then DONE
  task automatic build(input int n, input int skip_e);
    int ne;
    ne = (n > MAXE) ? MAXE : n;
    q.delete();
    q.push_back(mk(6'b000000, int'(m_idx), 2, 2));
    for (int k = 0; k < ne; k++) begin
      for (int w = 0; w < wa[k]; w++) q.push_back(mk(6'b100010, k, 0, 2));
      q.push_back(mk(6'b100010, k, 1, (k == skip_e) ? 1 : 0));
      if (!skip_active(k, skip_e)) begin
        q.push_back(mk(6'b101010, k, 2, 2));
        for (int w = 0; w < wf[k]; w++) q.push_back(mk(6'b010010, k, 0, 2));
        q.push_back(mk(6'b010010, k, 1, 2));
        q.push_back(mk(6'b011010, k, 2, 2));
      end
      q.push_back(mk(6'b000110, k, 2, 2));
    end
    q.push_back(mk(6'b000001, (ne == 0) ? 0 : ne - 1, 2, 2));
  endtask

  // kill_at: -1 none, -2 random point; kill_kind 0 = abort, 1 = reset
  task automatic run_job(input int n, input int skip_e, input int kill_at_in, input int kill_kind,
                         output int done_cyc, output int wr_cnt);
    int kill_at;
    build(n, skip_e);
    kill_at = (kill_at_in == -2) ? int'($urandom_range(1, q.size() - 1)) : kill_at_in;
    done_cyc = -1;
    wr_cnt   = 0;
    m_idx    = q[q.size() - 1].idx;
    for (int i = 0; i < q.size(); i++) begin
      start     = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      num_edges = (i == 0) ? EB'(n) : EB'($urandom_range(0, 127));
      mem_ready = (q[i].mr == 2) ? 1'($urandom_range(0, 1)) : 1'(q[i].mr);
      edge_skip = (q[i].sk == 2) ? 1'($urandom_range(0, 1)) : 1'(q[i].sk);
      abort     = (i == kill_at && kill_kind == 0);
      reset     = (i == kill_at && kill_kind == 1);
      chk_o($sformatf("outputs job%0d cyc%0d", n, i), obs, q[i].o);
      chk_i($sformatf("edge_idx job%0d cyc%0d", n, i), int'(edge_idx), int'(q[i].idx));
      if (done === 1'b1) done_cyc = i;
      if (wr_en === 1'b1) wr_cnt++;
      @(posedge clk); #1;
      if (i == kill_at) begin
        m_idx = (kill_kind == 1) ? '0 : q[i].idx;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0; mem_ready = 1'b0; edge_skip = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    chk_o({tag, " idle outputs"}, obs, 6'b000000);
    chk_i({tag, " idle edge_idx"}, int'(edge_idx), int'(m_idx));
    @(posedge clk); #1;
  endtask

  task automatic zero_waits();
    for (int k = 0; k < MAXE; k++) begin wa[k] = 0; wf[k] = 0; end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; mem_ready = 1'b0; edge_skip = 1'b0;
    num_edges = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_idx = '0;
    chk_o("reset outputs", obs, 6'b000000);
    chk_i("reset edge_idx", int'(edge_idx), 0);
    @(posedge clk); #1;

    // Three edges, no waits
    zero_waits();
    run_job(3, -1, -1, 0, dc, wc);
    chk_i("n3 done cycle", dc, 16);
    chk_i("n3 wr pulses", wc, 6);
    idle_check("n3");
    chk_i("n3 final idx", int'(edge_idx), 2);

    // Zero-edge job
    run_job(0, -1, -1, 0, dc, wc);
    chk_i("n0 done cycle", dc, 1);
    chk_i("n0 wr pulses", wc, 0);
    idle_check("n0");

    // Two edges, FM read stalled three cycles each
    zero_waits();
    wf[0] = 3; wf[1] = 3;
    run_job(2, -1, -1, 0, dc, wc);
    chk_i("n2 stall done cycle", dc, 17);
    idle_check("n2 stall");

    // Abort in edge 1 FM_RD of a four-edge job (cycle 8)
    zero_waits();
    run_job(4, -1, 8, 0, dc, wc);
    chk_i("abort no done", dc, -1);
    idle_check("abort");
    chk_i("abort idx", int'(edge_idx), 1);

    // Back-to-back: second start in the IDLE cycle right after done
    run_job(2, -1, -1, 0, dc, wc);
    chk_i("b2b first done", dc, 11);
    run_job(3, -1, -1, 0, dc, wc);
    chk_i("b2b second done", dc, 16);
    idle_check("b2b");

    // Skip request on edge 1
    run_job(3, 1, -1, 0, dc, wc);
`ifdef COO_EDGE_SKIP_EN
    chk_i("skip done cycle", dc, 13);
    chk_i("skip wr pulses", wc, 4);
`else
    chk_i("skip done cycle", dc, 16);
    chk_i("skip wr pulses", wc, 6);
`endif
    idle_check("skip");

    // Count above MAX_EDGES clamps to 64 edges
    run_job(100, -1, -1, 0, dc, wc);
    chk_i("clamp done cycle", dc, 5 * MAXE + 1);
    idle_check("clamp");

    // Reset mid-job
    run_job(3, -1, 7, 1, dc, wc);
    idle_check("midreset");
    chk_i("midreset idx", int'(edge_idx), 0);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      int n, sk, kill;
      for (int k = 0; k < MAXE; k++) begin
        wa[k] = $urandom_range(0, 3);
        wf[k] = $urandom_range(0, 3);
      end
      n    = $urandom_range(0, 10);
      sk   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1;
      kill = ($urandom_range(0, 3) == 0) ? -2 : -1;
      run_job(n, sk, kill, int'($urandom_range(0, 1)), dc, wc);
      if ($urandom_range(0, 1) == 1) idle_check("rand");
    end
    idle_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
